// File: rtl/bpm_estimator.sv
// Beat tracker: debounces onset edges, averages the last four beat intervals (ms) and
// converts the average to beats per minute with a 16-step restoring divider.
module bpm_estimator #(
    parameter int unsigned TICK_CYCLES     = 50000,
    parameter int unsigned MIN_INTERVAL_MS = 250,
    parameter int unsigned MAX_INTERVAL_MS = 2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        beat_pulse_in,
    output logic        beat_detected,
    output logic [15:0] BPM_estimate,
    output logic        bpm_valid
);

    localparam int unsigned PresW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PresW-1:0] PresLast = PresW'(TICK_CYCLES - 1);
    localparam logic [15:0] MinMs    = 16'(MIN_INTERVAL_MS);
    localparam logic [15:0] MaxMs    = 16'(MAX_INTERVAL_MS);
    localparam logic [15:0] Dividend = 16'd60000;

    typedef enum logic [2:0] {
        StWaitFirst,
        StTrack,
        StLoad,
        StDivide,
        StFinish
    } state_e;

    state_e             state_q, state_d;
    logic               prev_q;
    logic [PresW-1:0]   presc_q, presc_d;
    logic [15:0]        ms_q, ms_d;
    logic [15:0]        hist_q [4];
    logic [15:0]        hist_d [4];
    logic               hist_valid_q, hist_valid_d;
    logic [17:0]        sum_q, sum_d;
    logic [15:0]        divisor_q, divisor_d;
    logic [16:0]        rem_q, rem_d;
    logic [15:0]        quo_q, quo_d;
    logic [3:0]         iter_q, iter_d;
    logic               beat_q, beat_d;
    logic [15:0]        bpm_q, bpm_d;
    logic               valid_q, valid_d;

    logic               edge_det;
    logic               tick;
    logic               timeout;
    logic               run_cnt;
    logic               clr_cnt;
    logic               push;
    logic [15:0]        avg;
    logic [17:0]        rem_shift;
    logic               fits;
    logic [16:0]        rem_step;
    logic [15:0]        quo_step;

    assign edge_det = beat_pulse_in & ~prev_q;
    assign tick     = (presc_q == PresLast);
    assign timeout  = (ms_q == MaxMs);
    assign avg      = 16'(sum_q >> 2);

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
    assign rem_shift = {rem_q, quo_q[15]};
    assign fits      = (rem_shift >= {2'b00, divisor_q});
    assign rem_step  = fits ? 17'(rem_shift - {2'b00, divisor_q}) : 17'(rem_shift);
    assign quo_step  = {quo_q[14:0], fits};

    always_comb begin
        state_d      = state_q;
        beat_d       = 1'b0;
        bpm_d        = bpm_q;
        valid_d      = valid_q;
        hist_d       = hist_q;
        hist_valid_d = hist_valid_q;
        divisor_d    = divisor_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        iter_d       = iter_q;
        run_cnt      = 1'b0;
        clr_cnt      = 1'b0;
        push         = 1'b0;

        unique case (state_q)
            StWaitFirst: begin
                if (edge_det) begin
                    beat_d  = 1'b1;
                    clr_cnt = 1'b1;
                    state_d = StTrack;
                end
            end
            StTrack: begin
                run_cnt = 1'b1;
                if (timeout) begin
                    // A coincident edge becomes the new reference beat of an empty history.
                    for (int i = 0; i < 4; i++) hist_d[i] = '0;
                    hist_valid_d = 1'b0;
                    bpm_d        = '0;
                    valid_d      = 1'b0;
                    clr_cnt      = 1'b1;
                    if (edge_det) begin
                        beat_d  = 1'b1;
                        state_d = StTrack;
                    end else begin
                        state_d = StWaitFirst;
                    end
                end else if (edge_det && (ms_q >= MinMs)) begin
                    beat_d  = 1'b1;
                    clr_cnt = 1'b1;
                    push    = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                run_cnt   = 1'b1;
                divisor_d = avg;
                rem_d     = '0;
                quo_d     = Dividend;
                iter_d    = '0;
                state_d   = StDivide;
            end
            StDivide: begin
                run_cnt = 1'b1;
                rem_d   = rem_step;
                quo_d   = quo_step;
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                run_cnt = 1'b1;
                bpm_d   = quo_q;
                valid_d = 1'b1;
                state_d = StTrack;
            end
            default: begin
                state_d = StWaitFirst;
            end
        endcase

        if (push) begin
            if (hist_valid_q) begin
                hist_d[3] = hist_q[2];
                hist_d[2] = hist_q[1];
                hist_d[1] = hist_q[0];
                hist_d[0] = ms_q;
            end else begin
                for (int i = 0; i < 4; i++) hist_d[i] = ms_q;
                hist_valid_d = 1'b1;
            end
        end

        sum_d = 18'(hist_d[0]) + 18'(hist_d[1]) + 18'(hist_d[2]) + 18'(hist_d[3]);

        presc_d = presc_q;
        ms_d    = ms_q;
        if (clr_cnt) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (run_cnt) begin
            if (tick) begin
                presc_d = '0;
                if (ms_q != MaxMs) begin
                    ms_d = ms_q + 16'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StWaitFirst;
            prev_q       <= 1'b0;
            presc_q      <= '0;
            ms_q         <= '0;
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            hist_valid_q <= 1'b0;
            sum_q        <= '0;
            divisor_q    <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            iter_q       <= '0;
            beat_q       <= 1'b0;
            bpm_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= beat_pulse_in;
            presc_q      <= presc_d;
            ms_q         <= ms_d;
            for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
            hist_valid_q <= hist_valid_d;
            sum_q        <= sum_d;
            divisor_q    <= divisor_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            iter_q       <= iter_d;
            beat_q       <= beat_d;
            bpm_q        <= bpm_d;
            valid_q      <= valid_d;
        end
    end

    assign beat_detected = beat_q;
    assign BPM_estimate  = bpm_q;
    assign bpm_valid     = valid_q;

endmodule

// File: tb/tb_bpm_estimator.sv
// Directed bench for bpm_estimator with a 10-cycle millisecond tick.
`timescale 1ns/1ps
module tb_bpm_estimator;

    localparam int TICK = 10;

    logic        clk;
    logic        reset_n;
    logic        beat_pulse_in;
    logic        beat_detected;
    logic [15:0] BPM_estimate;
    logic        bpm_valid;

    int n_checks = 0;
    int n_errors = 0;
    int pulses;

    bpm_estimator #(
        .TICK_CYCLES    (TICK),
        .MIN_INTERVAL_MS(250),
        .MAX_INTERVAL_MS(2000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .beat_pulse_in(beat_pulse_in),
        .beat_detected(beat_detected),
        .BPM_estimate (BPM_estimate),
        .bpm_valid    (bpm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edge is sampled at the posedge after it is raised; the pulse is checked one negedge later.
    task automatic beat(input int wait_cyc, input logic exp_pulse, input string tag);
        wait_neg(wait_cyc);
        beat_pulse_in = 1'b1;
        @(negedge clk);
        beat_pulse_in = 1'b0;
        check_eq(tag, beat_detected, exp_pulse);
    endtask

    task automatic do_reset();
        beat_pulse_in = 1'b0;
        reset_n = 1'b0;
        wait_neg(3);
        reset_n = 1'b1;
        wait_neg(2);
    endtask

    // Waits from 18 cycles after the previous accepted pulse so the next edge lands at exactly ms.
    function automatic int gap(input int ms);
        return TICK * ms - 18;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_tempo [5];
        exp_tempo[0] = 126;
        exp_tempo[1] = 133;
        exp_tempo[2] = 141;
        exp_tempo[3] = 150;
        exp_tempo[4] = 150;

        // Reset
        reset_n = 1'b0;
        beat_pulse_in = 1'b0;
        wait_neg(3);
        check_eq("rst_beat", beat_detected, 0);
        check_eq("rst_bpm", BPM_estimate, 0);
        check_eq("rst_valid", bpm_valid, 0);
        reset_n = 1'b1;
        wait_neg(5);
        check_eq("post_rst_bpm", BPM_estimate, 0);
        beat_pulse_in = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (beat_detected) pulses++;
        end
        beat_pulse_in = 1'b0;
        check_eq("first_edge_pulses", pulses, 1);
        check_eq("first_edge_novalid", bpm_valid, 0);

        // Steady tempo at 500 ms, then tempo change to 400 ms
        do_reset();
        beat(4, 1'b1, "s_b1");
        wait_neg(18);
        check_eq("s_b1_novalid", bpm_valid, 0);
        beat(gap(500), 1'b1, "s_b2");
        wait_neg(17);
        check_eq("s_b2_valid_early", bpm_valid, 0);
        wait_neg(1);
        check_eq("s_b2_bpm", BPM_estimate, 120);
        check_eq("s_b2_valid", bpm_valid, 1);
        beat(gap(500), 1'b1, "s_b3");
        wait_neg(5);
        check_eq("s_b3_mid_divide", BPM_estimate, 120);
        wait_neg(13);
        check_eq("s_b3_bpm", BPM_estimate, 120);
        beat(gap(500), 1'b1, "s_b4");
        wait_neg(18);
        check_eq("s_b4_bpm", BPM_estimate, 120);
        for (int i = 0; i < 5; i++) begin
            beat(gap(400), 1'b1, $sformatf("tempo%0d_pulse", i));
            wait_neg(18);
            check_eq($sformatf("tempo%0d_bpm", i), BPM_estimate, exp_tempo[i]);
        end

        // Debounce: edge at +100 ms ignored, edge at +500 ms accepted
        do_reset();
        beat(4, 1'b1, "d_b1");
        wait_neg(18);
        beat(gap(100), 1'b0, "d_b2_ignored");
        beat(3999, 1'b1, "d_b3");
        wait_neg(18);
        check_eq("d_b3_bpm", BPM_estimate, 120);
        check_eq("d_b3_valid", bpm_valid, 1);

        // Timeout after 2000 ms without edges
        wait_neg(20001 - 19);
        check_eq("to_before_bpm", BPM_estimate, 120);
        check_eq("to_before_valid", bpm_valid, 1);
        wait_neg(1);
        check_eq("to_bpm", BPM_estimate, 0);
        check_eq("to_valid", bpm_valid, 0);
        beat(20, 1'b1, "to_first");
        wait_neg(18);
        check_eq("to_first_novalid", bpm_valid, 0);
        check_eq("to_first_bpm", BPM_estimate, 0);
        beat(gap(300), 1'b1, "to_b2");
        wait_neg(18);
        check_eq("to_b2_bpm", BPM_estimate, 200);
        check_eq("to_b2_valid", bpm_valid, 1);

        // Reset in the middle of a divide
        beat(gap(300), 1'b1, "rm_beat");
        wait_neg(9);
        reset_n = 1'b0;
        #1;
        check_eq("rm_beat_zero", beat_detected, 0);
        check_eq("rm_bpm_zero", BPM_estimate, 0);
        check_eq("rm_valid_zero", bpm_valid, 0);
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(30);
        check_eq("rm_after_bpm", BPM_estimate, 0);
        check_eq("rm_after_valid", bpm_valid, 0);

        // Input held high for 1000 ms gives a single pulse
        beat_pulse_in = 1'b1;
        pulses = 0;
        repeat (TICK * 1000) begin
            @(negedge clk);
            if (beat_detected) pulses++;
        end
        beat_pulse_in = 1'b0;
        check_eq("hold_high_pulses", pulses, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bpm_estimator.md
# bpm_estimator

Upstream beat-tracking stage for the pixel filter pipeline: converts raw onset pulses from the audio beat detector into a debounced `beat_detected` pulse and a smoothed `BPM_estimate`. These are the two control inputs the filter-stack FSM uses to choose its filter depth. The interval between accepted beats is measured in millisecond ticks and averaged over the last four intervals. A sequential restoring divider then converts the average to beats per minute.

## Interface
- `TICK_CYCLES`, default 50000: clock cycles per 1 ms tick (50 MHz clock).
- `MIN_INTERVAL_MS`, default 250: minimum accepted beat spacing (240 BPM maximum). Constraint: TICK_CYCLES*MIN_INTERVAL_MS > 20.
- `MAX_INTERVAL_MS`, default 2000: timeout spacing (30 BPM minimum). Constraint: MAX_INTERVAL_MS > MIN_INTERVAL_MS.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `beat_pulse_in` in 1: raw onset from the audio detector, synchronous to `clk`. Level or pulse; only rising edges count.
- `beat_detected` out 1: one-cycle pulse per accepted beat.
- `BPM_estimate` out 16: smoothed BPM, unsigned integer, truncated.
- `bpm_valid` out 1: high while `BPM_estimate` holds a computed value.

## Operation
- Edge detect: `beat_pulse_in` is registered into `prev`. An edge occurs in cycle N when `beat_pulse_in`=1 and `prev`=0.
- Prescaler: counts 0..TICK_CYCLES-1. At wrap, `ms_count` (16 bits) increments, saturating at MAX_INTERVAL_MS.
- States:
  - WAIT_FIRST: no reference beat yet. An edge is accepted, then `beat_detected` pulses, the prescaler and `ms_count` clear, and the FSM goes to TRACK. `ms_count` does not advance in this state.
  - TRACK:
    - Edge with `ms_count` < MIN_INTERVAL_MS: ignored. No pulse, counters untouched.
    - Edge with `ms_count` >= MIN_INTERVAL_MS: accepted. `beat_detected` pulses, the interval is the current `ms_count`, counters clear, and the interval enters history.
    - After history is updated, the FSM goes to DIVIDE.
    - `ms_count` == MAX_INTERVAL_MS: timeout. History clears, `BPM_estimate`=0, `bpm_valid`=0, and the FSM goes to WAIT_FIRST.
  - DIVIDE: 16-iteration restoring divide of 60000 by `avg`, one quotient bit per cycle. The prescaler and `ms_count` keep running. Edges are ignored; by the parameter constraint, `ms_count` is still below MIN. At completion, `BPM_estimate` and `bpm_valid` update and the FSM returns to TRACK.
- History: four 16-bit interval registers, h0 (newest) to h3.
  - First interval after WAIT_FIRST: written into all four entries (prefill). A history-valid flag is set.
  - Later intervals: shift in, h3 discarded.
  - `avg` = (h0+h1+h2+h3) >> 2, truncated. The 18-bit sum is held in the register.
- Divider: dividend is the constant 60000 (16 bits), divisor is `avg` (range MIN..MAX, never 0), with a 17-bit partial remainder. Quotient range is 30..240 at the defaults, which fits in 16 bits.
- Simultaneous timeout and edge in TRACK: the timeout is applied first, and the edge is then treated as a first beat. `beat_detected` pulses, `ms_count` clears and the FSM enters TRACK. History stays empty, `BPM_estimate`=0 and `bpm_valid`=0.
- Reset (any time, including mid-divide): the divide is abandoned. State WAIT_FIRST, all counters, history and divider registers 0.

## Timing
- Reset values: `beat_detected`=0, `BPM_estimate`=0, `bpm_valid`=0.
- Edge sampled in cycle N:
  - N+1: `beat_detected`=1 (registered), counters cleared, history written.
  - N+2: divider loaded from `avg`.
  - N+3..N+18: 16 iterations.
  - From N+19: new `BPM_estimate` visible and `bpm_valid`=1.
- `BPM_estimate` is stable between updates. It never shows a partial quotient.
- Timeout: `BPM_estimate`=0 and `bpm_valid`=0 visible the cycle after `ms_count` reaches MAX.
- Beat-to-estimate: the first accepted beat gives a pulse only. The second accepted beat gives the first valid BPM.

## Test plan
All scenarios use TICK_CYCLES=10 with default intervals.
- Reset: hold `reset_n`=0, then release -> all outputs 0, then `beat_detected` pulses exactly once on the first rising edge of `beat_pulse_in`.
- Steady tempo: edges every 500 ms -> after the second edge, `BPM_estimate`=120 and `bpm_valid`=1 exactly 18 cycles after the `beat_detected` pulse. The value stays 120 on later edges.
- Tempo change: four edges at 500 ms spacing, then edges every 400 ms -> successive estimates 126, 133, 141, 150, then 150 steady.
- Debounce: accepted edge, then a second edge 100 ms later, then a third edge 500 ms after the first -> no pulse for the second edge. The third edge yields an interval of 500 and `BPM_estimate`=120.
- Timeout: valid at 120 BPM, then no edges for 2000 ms -> `BPM_estimate`=0 and `bpm_valid`=0. The next edge pulses `beat_detected` but leaves `bpm_valid`=0. An edge 300 ms later gives `BPM_estimate`=200.
- Reset mid-divide: assert `reset_n` at N+10 after an accepted edge -> outputs immediately 0 and no stale quotient after release. Also hold `beat_pulse_in` high for 1000 ms -> only one pulse.
